// File: rtl/bcd_conv_seq.sv
// Multi-cycle binary-to-BCD converter: one shift-and-add-3 step per clock, valid/ready on both sides.
// Define BCD_CONV_SIGN_EN to treat in_bin as two's complement and report the sign on out_neg.
module bcd_conv_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
`ifdef BCD_CONV_SIGN_EN
  output logic                  out_neg,
`endif
  output logic                  out_ovf
);

  localparam int SR_W  = 1 + 4*DIGITS + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [SR_W-1:0]    sreg;
  logic [SR_W-1:0]    sreg_step;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   operand;
  logic               last_step;

  // Layout of sreg: {ovf_sticky, digit[DIGITS-1..0], binary}. Digits are corrected
  // independently; the carry out of the top digit is folded into the sticky flag.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] adj;
    adj = sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr[WIDTH+4*d +: 4] >= 4'd5)
        adj[WIDTH+4*d +: 4] = sr[WIDTH+4*d +: 4] + 4'd3;
    end
    dabble_step           = {adj[SR_W-2:0], 1'b0};
    dabble_step[SR_W-1]   = sr[SR_W-1] | adj[SR_W-2];
  endfunction

`ifdef BCD_CONV_SIGN_EN
  // The most negative value negates to itself, which reads correctly as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] neg_v;
    neg_v = -v;
    magnitude = v[WIDTH-1] ? $unsigned(neg_v) : $unsigned(v);
  endfunction

  assign operand = magnitude($signed(in_bin));
`else
  assign operand = in_bin;
`endif

  assign sreg_step = dabble_step(sreg);
  assign last_step = (count == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      count   <= '0;
      out_bcd <= '0;
      out_ovf <= 1'b0;
`ifdef BCD_CONV_SIGN_EN
      out_neg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg  <= {1'b0, {4*DIGITS{1'b0}}, operand};
            count <= CNT_W'(WIDTH);
`ifdef BCD_CONV_SIGN_EN
            out_neg <= in_bin[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          sreg  <= sreg_step;
          count <= count - CNT_W'(1);
          if (last_step) begin
            out_bcd <= sreg_step[WIDTH +: 4*DIGITS];
            out_ovf <= sreg_step[SR_W-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Scoreboard bench for bcd_conv_seq: a 3-digit and a 2-digit instance run in lockstep
// on the same stimulus and are checked against a decimal-arithmetic model.
module tb_bcd_conv_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_bin = '0;
  logic         in_ready3, out_valid3, ovf3;
  logic         in_ready2, out_valid2, ovf2;
  logic [11:0]  bcd3;
  logic [7:0]   bcd2;
`ifdef BCD_CONV_SIGN_EN
  logic         neg3, neg2;
`endif

  bcd_conv_seq #(.WIDTH(W), .DIGITS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3), .in_bin(in_bin),
    .out_valid(out_valid3), .out_ready(out_ready), .out_bcd(bcd3),
`ifdef BCD_CONV_SIGN_EN
    .out_neg(neg3),
`endif
    .out_ovf(ovf3));

  bcd_conv_seq #(.WIDTH(W), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_bin(in_bin),
    .out_valid(out_valid2), .out_ready(out_ready), .out_bcd(bcd2),
`ifdef BCD_CONV_SIGN_EN
    .out_neg(neg2),
`endif
    .out_ovf(ovf2));

  typedef struct {
    logic [11:0] bcd3;
    logic        ovf3;
    logic [7:0]  bcd2;
    logic        ovf2;
    logic        neg;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   rand_ready = 1'b0;
  bit   prev_v = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] v, input int acc);
    exp_t e;
    int   mag, r3, r2;
`ifdef BCD_CONV_SIGN_EN
    e.neg = v[W-1];
    mag   = v[W-1] ? (1 << W) - int'(v) : int'(v);
`else
    e.neg = 1'b0;
    mag   = int'(v);
`endif
    r3 = mag % 1000;
    r2 = mag % 100;
    e.bcd3 = {4'(r3 / 100), 4'((r3 / 10) % 10), 4'(r3 % 10)};
    e.bcd2 = {4'(r2 / 10), 4'(r2 % 10)};
    e.ovf3 = (mag >= 1000);
    e.ovf2 = (mag >= 100);
    e.acc  = acc;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [W-1:0] v);
    int n = 0;
    in_bin   = v;
    in_valid = 1'b1;
    while (!in_ready3 && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) check("accept_timeout", 32'(n), 32'(0));
    tick();
    q.push_back(model(v, cyc));
    in_valid = 1'b0;
    in_bin   = W'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 1000) begin
      tick();
      n++;
    end
    if (q.size() > 0) begin
      check("drain_timeout", 32'(q.size()), 32'(0));
      q.delete();
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (rand_ready) out_ready = ($urandom_range(3) != 0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid3 && !prev_v) begin
        if (q.size() == 0) check("spurious_valid", 32'(out_valid3), 32'(0));
        else               check("latency", 32'(cyc - q[0].acc), 32'(W));
      end
      if (out_valid3 && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", 32'(bcd3), 32'hFFFF);
        end else begin
          e = q.pop_front();
          check("bcd_d3", 32'(bcd3), 32'(e.bcd3));
          check("ovf_d3", 32'(ovf3), 32'(e.ovf3));
          check("valid_d2", 32'(out_valid2), 32'(1));
          check("bcd_d2", 32'(bcd2), 32'(e.bcd2));
          check("ovf_d2", 32'(ovf2), 32'(e.ovf2));
`ifdef BCD_CONV_SIGN_EN
          check("neg_d3", 32'(neg3), 32'(e.neg));
          check("neg_d2", 32'(neg2), 32'(e.neg));
`endif
        end
      end
      prev_v = out_valid3;
    end
  end

  initial begin
    logic [11:0] hold;
    logic [W-1:0] perm [256];
    int n;

    #1;
    check("rst_in_ready", 32'(in_ready3), 32'(1));
    check("rst_out_valid", 32'(out_valid3), 32'(0));
    check("rst_bcd", 32'(bcd3), 32'(0));
    check("rst_ovf", 32'(ovf3), 32'(0));
`ifdef BCD_CONV_SIGN_EN
    check("rst_neg", 32'(neg3), 32'(0));
`endif
    tick();
    rst_n = 1'b1;
    tick();

    out_ready = 1'b1;
    send(8'd255);
    drain();

    send(8'd0);
    send(8'd99);
    check("busy_in_ready", 32'(in_ready3), 32'(0));
    send(8'd100);
    drain();

    out_ready = 1'b0;
    send(8'd123);
    n = 0;
    while (!out_valid3 && n < 50) begin
      tick();
      n++;
    end
    check("bp_valid", 32'(out_valid3), 32'(1));
    hold     = bcd3;
    in_valid = 1'b1;
    in_bin   = 8'd77;
    repeat (20) begin
      tick();
      check("bp_hold_valid", 32'(out_valid3), 32'(1));
      check("bp_hold_bcd", 32'(bcd3), 32'(hold));
      check("bp_in_ready", 32'(in_ready3), 32'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid3), 32'(0));
    check("bp_release_ready", 32'(in_ready3), 32'(1));
    check("bp_queue_empty", 32'(q.size()), 32'(0));

    send(8'd173);
    tick();
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid3), 32'(0));
    check("midrst_in_ready", 32'(in_ready3), 32'(1));
    check("midrst_bcd", 32'(bcd3), 32'(0));
    check("midrst_ovf", 32'(ovf3), 32'(0));
    q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    send(8'd42);
    drain();

    send(8'h80);
    send(8'hFF);
    send(8'h7F);
    send(8'd200);
    drain();

    for (int i = 0; i < 256; i++) perm[i] = W'(i);
    for (int i = 255; i > 0; i--) begin
      int j;
      logic [W-1:0] t;
      j = $urandom_range(i);
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    rand_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send(perm[i]);
      if ($urandom_range(3) == 0) repeat ($urandom_range(3)) tick();
    end
    repeat (64) send(W'($urandom));
    drain();
    rand_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
